// File: rtl/decoder_stage.sv
// decoder_stage: registered MIPS instruction decode stage with a DEPTH-entry
// decoded-record buffer. It has valid/ready handshakes on both the fetch side and
// the register-read side.
// Each accepted word is decoded on entry. The buffer stores the raw word, the PC,
// the extended immediate and the resolved class, destination and write-enable.
// The raw fields are re-sliced from the stored word at the head.
// Optional build macro: DECODE_ILLEGAL_EN adds the out_illegal output. That build
// decodes unknown opcodes and unlisted R-type functs as class 7 with no register
// write.
module decoder_stage #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int EXT_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       out_opcode,
  output logic [5:0]       out_funct,
  output logic [4:0]       out_shamt,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [EXT_W-1:0] out_imm,
  output logic [25:0]      out_jaddr,
  output logic [4:0]       out_dst,
  output logic             out_wen,
  output logic [2:0]       out_class,
`ifdef DECODE_ILLEGAL_EN
  output logic             out_illegal,
`endif
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;

  logic [31:0]      mem_instr [DEPTH];
  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [EXT_W-1:0] mem_imm   [DEPTH];
  logic [2:0]       mem_class [DEPTH];
  logic [4:0]       mem_dst   [DEPTH];
  logic             mem_wen   [DEPTH];
`ifdef DECODE_ILLEGAL_EN
  logic             mem_ill   [DEPTH];
  logic             dec_ill;
`endif

  logic [5:0]       op, fn;
  logic [4:0]       in_rt, in_rd;
  logic [15:0]      imm16;
  logic [2:0]       dec_class;
  logic [4:0]       dec_dst, dst_raw;
  logic             dec_wen, wen_raw;
  logic [EXT_W-1:0] dec_imm;

  assign op    = in_instr[31:26];
  assign fn    = in_instr[5:0];
  assign in_rt = in_instr[20:16];
  assign in_rd = in_instr[15:11];
  assign imm16 = in_instr[15:0];

  assign in_ready  = in_ready_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Resolve class, destination and write-enable from the incoming word.
  always_comb begin
    dec_class = 3'd7;
    dst_raw   = '0;
    wen_raw   = 1'b0;
    case (op)
      6'h00: begin
        dst_raw = in_rd;
        if (fn == 6'h08) begin
          dec_class = 3'd5;
        end else begin
          dec_class = 3'd0;
          wen_raw   = 1'b1;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_class = 3'd1;
        dst_raw   = in_rt;
        wen_raw   = 1'b1;
      end
      6'h23, 6'h30: begin
        dec_class = 3'd2;
        dst_raw   = in_rt;
        wen_raw   = 1'b1;
      end
      6'h2B: dec_class = 3'd3;
      6'h38: begin
        dec_class = 3'd3;
        dst_raw   = in_rt;
        wen_raw   = 1'b1;
      end
      6'h04, 6'h05: dec_class = 3'd4;
      6'h02: dec_class = 3'd5;
      6'h03: begin
        dec_class = 3'd5;
        dst_raw   = 5'd31;
        wen_raw   = 1'b1;
      end
      6'h3F: dec_class = 3'd6;
      default: ;
    endcase
`ifdef DECODE_ILLEGAL_EN
    dec_ill = 1'b0;
    if (dec_class == 3'd7) begin
      dec_ill = 1'b1;
    end else if (op == 6'h00) begin
      case (fn)
        6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ;
        default: dec_ill = 1'b1;
      endcase
    end
    if (dec_ill) begin
      dec_class = 3'd7;
      wen_raw   = 1'b0;
    end
`endif
    // $0 is never a real destination, and a non-writing entry reports dst 0.
    dec_wen = wen_raw & (dst_raw != 5'd0);
    dec_dst = dec_wen ? dst_raw : 5'd0;
  end

  // Immediate extension: the logical ops zero-extend, LUI shifts, the rest sign-extend.
  always_comb begin
    dec_imm = {{(EXT_W-16){imm16[15]}}, imm16};
    case (op)
      6'h0C, 6'h0D, 6'h0E: begin
        dec_imm        = '0;
        dec_imm[15:0]  = imm16;
      end
      6'h0F: begin
        dec_imm        = '0;
        dec_imm[31:16] = imm16;
      end
      default: ;
    endcase
  end

  // Occupancy change for this cycle's push/pop combination.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Pointer, occupancy and registered ready. Reset wins over flush, and flush wins over push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Record storage. It is not reset because empty-buffer outputs are masked to zero.
  always_ff @(posedge CLK) begin
    if (!RST && !flush && push) begin
      mem_instr[wr_ptr_q] <= in_instr;
      mem_pc[wr_ptr_q]    <= in_pc;
      mem_imm[wr_ptr_q]   <= dec_imm;
      mem_class[wr_ptr_q] <= dec_class;
      mem_dst[wr_ptr_q]   <= dec_dst;
      mem_wen[wr_ptr_q]   <= dec_wen;
`ifdef DECODE_ILLEGAL_EN
      mem_ill[wr_ptr_q]   <= dec_ill;
`endif
    end
  end

  // Head entry presented to the consumer. All fields are zero while the buffer is empty.
  always_comb begin
    out_pc     = '0;
    out_opcode = '0;
    out_funct  = '0;
    out_shamt  = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_rd     = '0;
    out_imm    = '0;
    out_jaddr  = '0;
    out_dst    = '0;
    out_wen    = 1'b0;
    out_class  = '0;
`ifdef DECODE_ILLEGAL_EN
    out_illegal = 1'b0;
`endif
    if (out_valid) begin
      out_pc     = mem_pc[rd_ptr_q];
      out_opcode = mem_instr[rd_ptr_q][31:26];
      out_rs     = mem_instr[rd_ptr_q][25:21];
      out_rt     = mem_instr[rd_ptr_q][20:16];
      out_rd     = mem_instr[rd_ptr_q][15:11];
      out_shamt  = mem_instr[rd_ptr_q][10:6];
      out_funct  = mem_instr[rd_ptr_q][5:0];
      out_jaddr  = mem_instr[rd_ptr_q][25:0];
      out_imm    = mem_imm[rd_ptr_q];
      out_dst    = mem_dst[rd_ptr_q];
      out_wen    = mem_wen[rd_ptr_q];
      out_class  = mem_class[rd_ptr_q];
`ifdef DECODE_ILLEGAL_EN
      out_illegal = mem_ill[rd_ptr_q];
`endif
    end
  end

endmodule

// File: tb/tb_decoder_stage.sv
// tb_decoder_stage: table-driven decode vectors, hand-written buffer sequences
// (full, flush, reset-over-flush), then randomized traffic checked against a
// queue-based reference model.
module tb_decoder_stage;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int EXT_W = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [5:0]       out_opcode, out_funct;
  logic [4:0]       out_shamt, out_rs, out_rt, out_rd, out_dst;
  logic [EXT_W-1:0] out_imm;
  logic [25:0]      out_jaddr;
  logic             out_wen;
  logic [2:0]       out_class;
  logic [CNT_W-1:0] count;
`ifdef DECODE_ILLEGAL_EN
  logic             out_illegal;
`endif

  decoder_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .EXT_W(EXT_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
    .out_jaddr(out_jaddr), .out_dst(out_dst), .out_wen(out_wen), .out_class(out_class),
`ifdef DECODE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  dst;
    logic        wen;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vt[16];
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference decode derived directly from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  tgt;
    logic        writes;
    logic [15:0] i16;
    op = w[31:26];
    fn = w[5:0];
    i16 = w[15:0];
    tgt = 5'd0;
    writes = 1'b0;
    e.ill = 1'b0;
    e.cls = 3'd7;
    if (op == 6'h00) begin
      e.cls = (fn == 6'h08) ? 3'd5 : 3'd0;
      tgt = w[15:11];
      writes = (fn != 6'h08);
      if (ILL_EN && !(fn inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                                 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}))
        e.ill = 1'b1;
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      e.cls = 3'd1; tgt = w[20:16]; writes = 1'b1;
    end else if (op inside {6'h23, 6'h30}) begin
      e.cls = 3'd2; tgt = w[20:16]; writes = 1'b1;
    end else if (op == 6'h2B) begin
      e.cls = 3'd3;
    end else if (op == 6'h38) begin
      e.cls = 3'd3; tgt = w[20:16]; writes = 1'b1;
    end else if (op inside {6'h04, 6'h05}) begin
      e.cls = 3'd4;
    end else if (op == 6'h02) begin
      e.cls = 3'd5;
    end else if (op == 6'h03) begin
      e.cls = 3'd5; tgt = 5'd31; writes = 1'b1;
    end else if (op == 6'h3F) begin
      e.cls = 3'd6;
    end else begin
      e.ill = ILL_EN;
    end
    if (e.ill) begin
      e.cls = 3'd7;
      writes = 1'b0;
    end
    e.wen = writes && (tgt != 5'd0);
    e.dst = e.wen ? tgt : 5'd0;
    if (op inside {6'h0C, 6'h0D, 6'h0E}) e.imm = {16'h0000, i16};
    else if (op == 6'h0F)                e.imm = {i16, 16'h0000};
    else                                 e.imm = {{16{i16[15]}}, i16};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [21];
    logic [31:0] r;
    logic [5:0]  legal_fn [13];
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38, 6'h3F, 6'h3E, 6'h11};
    legal_fn = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    r = $urandom();
    r[31:26] = ops[$urandom_range(0, 20)];
    if (r[31:26] == 6'h00 && $urandom_range(0, 3) != 0)
      r[5:0] = legal_fn[$urandom_range(0, 12)];
    return r;
  endfunction

  task automatic check_head(input string name, input logic [31:0] w, input logic [31:0] pc,
                            input exp_t e);
    chk({name, " valid"}, out_valid, 1);
    chk({name, " class/dst/wen"}, {out_class, out_dst, out_wen}, {e.cls, e.dst, e.wen});
    chk({name, " imm"}, out_imm, e.imm);
    chk({name, " fields"},
        {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_jaddr},
        {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], w[25:0]});
    chk({name, " pc"}, out_pc, pc);
`ifdef DECODE_ILLEGAL_EN
    chk({name, " illegal"}, out_illegal, e.ill);
`endif
  endtask

  task automatic check_empty(input string name);
    chk({name, " count"}, count, 0);
    chk({name, " valid"}, out_valid, 0);
    chk({name, " zero fields"},
        {out_class, out_dst, out_wen, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, 0);
    chk({name, " zero imm/jaddr"}, {out_jaddr, out_imm}, 0);
    chk({name, " zero pc"}, out_pc, 0);
  endtask

  function automatic exp_t mk(input logic [2:0] c, input logic [4:0] d, input logic we,
                              input logic [31:0] im, input logic il);
    exp_t e;
    e.cls = c; e.dst = d; e.wen = we; e.imm = im; e.ill = il;
    return e;
  endfunction

  initial begin
    logic        mrdy;
    logic        fl, iv, ordy;
    logic [31:0] w, pc;
    ent_t        ent;

    vt[0]  = '{32'h012A4020, mk(3'd0, 5'd8,  1'b1, 32'h00004020, 1'b0)};
    vt[1]  = '{32'h3508FFFF, mk(3'd1, 5'd8,  1'b1, 32'h0000FFFF, 1'b0)};
    vt[2]  = '{32'h2108FFFF, mk(3'd1, 5'd8,  1'b1, 32'hFFFFFFFF, 1'b0)};
    vt[3]  = '{32'h3C081234, mk(3'd1, 5'd8,  1'b1, 32'h12340000, 1'b0)};
    vt[4]  = '{32'h0C000010, mk(3'd5, 5'd31, 1'b1, 32'h00000010, 1'b0)};
    vt[5]  = '{32'hAD090004, mk(3'd3, 5'd0,  1'b0, 32'h00000004, 1'b0)};
    vt[6]  = '{32'h03E00008, mk(3'd5, 5'd0,  1'b0, 32'h00000008, 1'b0)};
    vt[7]  = '{32'h11090003, mk(3'd4, 5'd0,  1'b0, 32'h00000003, 1'b0)};
    vt[8]  = '{32'h8D0A0000, mk(3'd2, 5'd10, 1'b1, 32'h00000000, 1'b0)};
    vt[9]  = '{32'h01290020, mk(3'd0, 5'd0,  1'b0, 32'h00000020, 1'b0)};
    vt[10] = '{32'hFC000000, mk(3'd6, 5'd0,  1'b0, 32'h00000000, 1'b0)};
    vt[11] = '{32'hF8000000, mk(3'd7, 5'd0,  1'b0, 32'h00000000, ILL_EN)};
    vt[12] = '{32'h0000403F, mk(ILL_EN ? 3'd7 : 3'd0, ILL_EN ? 5'd0 : 5'd8, !ILL_EN,
                                32'h0000403F, ILL_EN)};
    vt[13] = '{32'hE1090000, mk(3'd3, 5'd9,  1'b1, 32'h00000000, 1'b0)};
    vt[14] = '{32'h31088000, mk(3'd1, 5'd8,  1'b1, 32'h00008000, 1'b0)};
    vt[15] = '{32'h25088000, mk(3'd1, 5'd8,  1'b1, 32'hFFFF8000, 1'b0)};

    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) tick();
    check_empty("reset");
    chk("reset in_ready", in_ready, 0);
    RST = 1'b0;
    tick();
    chk("post-reset in_ready", in_ready, 1);

    // Decode table: push one word, check it at the head, then pop it.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_instr = vt[i].w; in_pc = 32'h1000 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d count", i), count, 1);
      check_head($sformatf("vec%0d", i), vt[i].w, 32'h1000 + 32'(i * 4), vt[i].e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), {out_valid, count}, 0);
    end

    // Fill to DEPTH with the consumer stalled. The head must hold while more words are offered.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = vt[i + 1].w; in_pc = 32'h2000 + 32'(i);
      tick();
    end
    chk("full in_ready", in_ready, 0);
    chk("full count", count, DEPTH);
    in_instr = vt[6].w; in_pc = 32'h2FFF;
    repeat (2) tick();
    chk("stall count", count, DEPTH);
    check_head("stall head", vt[1].w, 32'h2000, vt[1].e);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop-one in_ready", in_ready, 1);
    chk("pop-one count", count, DEPTH - 1);
    check_head("pop-one head", vt[2].w, 32'h2001, vt[2].e);
    in_valid = 1'b1; in_instr = vt[3].w; in_pc = 32'h2002; out_ready = 1'b1;
    tick();
    chk("push+pop count", count, DEPTH - 1);
    check_head("push+pop head", vt[3].w, 32'h2002, vt[3].e);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("drain count", count, 0);

    // Flush with a full buffer and a simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = vt[i].w; in_pc = 32'h3000 + 32'(i);
      tick();
    end
    in_valid = 1'b1; in_instr = vt[4].w; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush");
    chk("flush in_ready", in_ready, 1);
    tick();
    chk("flush push absent", {out_valid, count}, 0);

    // Reset takes priority over flush.
    in_valid = 1'b1; in_instr = vt[0].w;
    tick();
    RST = 1'b1; flush = 1'b1;
    tick();
    chk("rst+flush in_ready", in_ready, 0);
    check_empty("rst+flush");
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    // Randomized traffic against the queue model.
    q.delete();
    mrdy = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      fl   = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      w    = rand_instr();
      pc   = $urandom();
      flush = fl; in_valid = iv; out_ready = ordy; in_instr = w; in_pc = pc;
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (ordy && q.size() > 0) void'(q.pop_front());
        if (iv && mrdy) begin
          ent.w = w; ent.pc = pc;
          q.push_back(ent);
        end
      end
      mrdy = (q.size() != DEPTH);
      chk($sformatf("rand%0d count", cyc), count, q.size());
      chk($sformatf("rand%0d in_ready", cyc), in_ready, mrdy);
      if (q.size() > 0) check_head($sformatf("rand%0d", cyc), q[0].w, q[0].pc, ref_dec(q[0].w));
      else check_empty($sformatf("rand%0d", cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
